// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants and types for the VGA timing source.
//   - 640x480@60 timing (totals, active area, porches, sync widths)
//   - DEFAULT_FRAMES_PER_TICK: game-tick pacing
//   - COUNT_W: width of the column/row counters
//   - vga_pos_t: column/row pair carried through the counter logic
//   - in_window(): half-open range decode used by the porch sync outputs
package vga_timing_pkg;

  localparam int TOTAL_COLS     = 800;
  localparam int TOTAL_ROWS     = 525;
  localparam int ACTIVE_COLS    = 640;
  localparam int ACTIVE_ROWS    = 480;
  localparam int H_FRONT_PORCH  = 16;
  localparam int H_SYNC_WIDTH   = 96;
  localparam int V_FRONT_PORCH  = 10;
  localparam int V_SYNC_WIDTH   = 2;

  localparam int DEFAULT_FRAMES_PER_TICK = 30;

  localparam int COUNT_W = 10;

  typedef logic [COUNT_W-1:0] count_t;

  typedef struct packed {
    count_t col;
    count_t row;
  } vga_pos_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input count_t v, input count_t lo,
                                     input count_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/frame_tick_div.sv
// frame_tick_div
//   Divides frame starts down to a game tick every c_FRAMES_PER_TICK counted
//   frames. Frames are only counted while i_En is high; with i_En low the
//   count holds, so re-enabling resumes where it left off.
//
//   i_Frame_Start is expected one cycle ahead of the registered frame-start
//   strobe, so o_Tick (registered here) lines up with that strobe.
//
// Ports
//   i_Clk          pixel clock
//   i_Reset        synchronous active-high reset, clears the frame count
//   i_Frame_Start  next-cycle frame-start decode
//   i_En           count enable
//   o_Tick         one-cycle game tick
module frame_tick_div
  import vga_timing_pkg::*;
#(
  parameter int c_FRAMES_PER_TICK = DEFAULT_FRAMES_PER_TICK
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Frame_Start,
  input  logic i_En,
  output logic o_Tick
);

  localparam int CNT_W = (c_FRAMES_PER_TICK > 1) ? $clog2(c_FRAMES_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(c_FRAMES_PER_TICK - 1);

  if (c_FRAMES_PER_TICK < 1) begin : g_bad_div
    $error("frame_tick_div: c_FRAMES_PER_TICK must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q;
  logic             hit;
  logic             at_last;

  assign hit     = i_Frame_Start && i_En;
  assign at_last = (cnt_q == LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q  <= '0;
      o_Tick <= 1'b0;
    end else begin
      o_Tick <= hit && at_last;
      if (hit) begin
        cnt_q <= at_last ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA timing source: column/row counters, raw and porch-corrected sync,
//   frame-start strobe and game-tick strobe.
//
//   Every output is registered and decoded from the next-state counter
//   values, so on any cycle each sync/strobe output describes exactly the
//   o_Col_Count/o_Row_Count shown in that cycle.
//
// Ports
//   i_Clk          25 MHz pixel clock
//   i_Reset        synchronous active-high reset
//   i_Tick_En      enables game-tick frame counting
//   o_HSync        1 while col < c_ACTIVE_COLS
//   o_VSync        1 while row < c_ACTIVE_ROWS
//   o_HSync_Porch  connector HSync, active-low pulse
//   o_VSync_Porch  connector VSync, active-low pulse
//   o_Col_Count    current column
//   o_Row_Count    current row
//   o_Active       o_HSync & o_VSync
//   o_Frame_Start  one cycle on wrap to (0,0)
//   o_Game_Tick    one cycle every c_FRAMES_PER_TICK counted frame starts
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int c_TOTAL_COLS      = TOTAL_COLS,
  parameter int c_TOTAL_ROWS      = TOTAL_ROWS,
  parameter int c_ACTIVE_COLS     = ACTIVE_COLS,
  parameter int c_ACTIVE_ROWS     = ACTIVE_ROWS,
  parameter int c_H_FRONT_PORCH   = H_FRONT_PORCH,
  parameter int c_H_SYNC_WIDTH    = H_SYNC_WIDTH,
  parameter int c_V_FRONT_PORCH   = V_FRONT_PORCH,
  parameter int c_V_SYNC_WIDTH    = V_SYNC_WIDTH,
  parameter int c_FRAMES_PER_TICK = DEFAULT_FRAMES_PER_TICK
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Tick_En,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_HSync_Porch,
  output logic               o_VSync_Porch,
  output logic [COUNT_W-1:0] o_Col_Count,
  output logic [COUNT_W-1:0] o_Row_Count,
  output logic               o_Active,
  output logic               o_Frame_Start,
  output logic               o_Game_Tick
);

  // Sync pulses must sit entirely inside the blanking interval.
  if (c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH > c_TOTAL_COLS) begin : g_bad_h
    $error("vga_timing_gen: horizontal porch + sync exceeds blanking");
  end
  if (c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH > c_TOTAL_ROWS) begin : g_bad_v
    $error("vga_timing_gen: vertical porch + sync exceeds blanking");
  end

  localparam count_t COL_LAST = COUNT_W'(c_TOTAL_COLS - 1);
  localparam count_t ROW_LAST = COUNT_W'(c_TOTAL_ROWS - 1);
  localparam count_t H_ACT    = COUNT_W'(c_ACTIVE_COLS);
  localparam count_t V_ACT    = COUNT_W'(c_ACTIVE_ROWS);
  localparam count_t H_PS     = COUNT_W'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
  localparam count_t H_PE     = COUNT_W'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH);
  localparam count_t V_PS     = COUNT_W'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
  localparam count_t V_PE     = COUNT_W'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH);

  vga_pos_t pos_q;
  vga_pos_t pos_d;
  logic     col_wrap;
  logic     row_wrap;
  logic     frame_wrap;

  always_comb begin
    pos_d      = pos_q;
    col_wrap   = (pos_q.col == COL_LAST);
    row_wrap   = (pos_q.row == ROW_LAST);
    frame_wrap = col_wrap && row_wrap;
    if (col_wrap) begin
      pos_d.col = '0;
      pos_d.row = row_wrap ? '0 : pos_q.row + COUNT_W'(1);
    end else begin
      pos_d.col = pos_q.col + COUNT_W'(1);
    end
  end

  // Decodes use pos_d so the registered outputs align with the counts.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pos_q         <= '0;
      o_HSync       <= 1'b1;
      o_VSync       <= 1'b1;
      o_Active      <= 1'b1;
      o_HSync_Porch <= 1'b1;
      o_VSync_Porch <= 1'b1;
      o_Frame_Start <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      o_HSync       <= (pos_d.col < H_ACT);
      o_VSync       <= (pos_d.row < V_ACT);
      o_Active      <= (pos_d.col < H_ACT) && (pos_d.row < V_ACT);
      o_HSync_Porch <= !in_window(pos_d.col, H_PS, H_PE);
      o_VSync_Porch <= !in_window(pos_d.row, V_PS, V_PE);
      // Only a real wrap counts; the (0,0) seen after reset does not.
      o_Frame_Start <= frame_wrap;
    end
  end

  assign o_Col_Count = pos_q.col;
  assign o_Row_Count = pos_q.row;

  // Fed the pre-register wrap so the tick lands with o_Frame_Start.
  frame_tick_div #(
    .c_FRAMES_PER_TICK(c_FRAMES_PER_TICK)
  ) u_tick_div (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Frame_Start(frame_wrap),
    .i_En         (i_Tick_En),
    .o_Tick       (o_Game_Tick)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (20x10, one frame = 200
// cycles) so several frames fit in a short run. A second instance with one
// frame per tick shares the inputs.
module tb_vga_timing_gen;

  localparam int TC    = 20;
  localparam int TR    = 10;
  localparam int AC    = 12;
  localparam int AR    = 6;
  localparam int HFP   = 2;
  localparam int HSW   = 3;
  localparam int VFP   = 1;
  localparam int VSW   = 2;
  localparam int FPT   = 3;
  localparam int FRAME = TC * TR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;

  logic       hs, vs, hp, vp, act, fs, tick;
  logic [9:0] col, row;
  logic       hs1, vs1, hp1, vp1, act1, fs1, tick1;
  logic [9:0] col1, row1;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .c_TOTAL_COLS(TC), .c_TOTAL_ROWS(TR), .c_ACTIVE_COLS(AC), .c_ACTIVE_ROWS(AR),
    .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_V_FRONT_PORCH(VFP),
    .c_V_SYNC_WIDTH(VSW), .c_FRAMES_PER_TICK(FPT)
  ) u_dut (
    .i_Clk(clk), .i_Reset(rst), .i_Tick_En(en),
    .o_HSync(hs), .o_VSync(vs), .o_HSync_Porch(hp), .o_VSync_Porch(vp),
    .o_Col_Count(col), .o_Row_Count(row), .o_Active(act),
    .o_Frame_Start(fs), .o_Game_Tick(tick)
  );

  vga_timing_gen #(
    .c_TOTAL_COLS(TC), .c_TOTAL_ROWS(TR), .c_ACTIVE_COLS(AC), .c_ACTIVE_ROWS(AR),
    .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_V_FRONT_PORCH(VFP),
    .c_V_SYNC_WIDTH(VSW), .c_FRAMES_PER_TICK(1)
  ) u_dut1 (
    .i_Clk(clk), .i_Reset(rst), .i_Tick_En(en),
    .o_HSync(hs1), .o_VSync(vs1), .o_HSync_Porch(hp1), .o_VSync_Porch(vp1),
    .o_Col_Count(col1), .o_Row_Count(row1), .o_Active(act1),
    .o_Frame_Start(fs1), .o_Game_Tick(tick1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: cycles since reset release and number of counted frame starts.
  int   m_t   = 0;
  int   m_cnt = 0;
  logic m_fs = 1'b0, m_tick = 1'b0, m_tick1 = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t <= 0; m_cnt <= 0; m_fs <= 1'b0; m_tick <= 1'b0; m_tick1 <= 1'b0;
    end else begin
      m_t     <= m_t + 1;
      m_fs    <= ((m_t + 1) % FRAME) == 0;
      m_tick  <= 1'b0;
      m_tick1 <= 1'b0;
      if ((((m_t + 1) % FRAME) == 0) && en) begin
        m_cnt   <= m_cnt + 1;
        m_tick  <= ((m_cnt + 1) % FPT) == 0;
        m_tick1 <= 1'b1;
      end
    end
  end

  // Per-cycle compare plus a log of which frame starts carried a tick.
  bit chk_en = 1'b0;
  int fs_idx = 0;
  int fs_cyc[$];
  int tick_at[$];
  int tick1_n = 0;
  int cyc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int ec, er;
      ec = m_t % TC;
      er = (m_t / TC) % TR;
      chk("col",    col,  ec);
      chk("row",    row,  er);
      chk("hsync",  hs,   ec < AC);
      chk("vsync",  vs,   er < AR);
      chk("active", act,  (ec < AC) && (er < AR));
      chk("hporch", hp,   !((ec >= AC + HFP) && (ec < AC + HFP + HSW)));
      chk("vporch", vp,   !((er >= AR + VFP) && (er < AR + VFP + VSW)));
      chk("fstart", fs,   m_fs);
      chk("tick",   tick, m_tick);
      chk("fstart1", fs1,  m_fs);
      chk("tick1",   tick1, m_tick1);
      chk("align_h", hs,  col < AC);
      chk("align_a", act, hs & vs);
      if (fs === 1'b1) begin
        fs_idx++;
        fs_cyc.push_back(cyc);
      end
      if (tick === 1'b1) tick_at.push_back(fs_idx);
      if (tick1 === 1'b1) tick1_n++;
    end
  end

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    fs_idx = 0;
    fs_cyc.delete();
    tick_at.delete();
    tick1_n = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    step(3);
    chk_en = 1'b1;
    // Reset values
    chk("rst_col", col, 0);   chk("rst_row", row, 0);
    chk("rst_hs", hs, 1);     chk("rst_vs", vs, 1);   chk("rst_act", act, 1);
    chk("rst_hp", hp, 1);     chk("rst_vp", vp, 1);
    chk("rst_fs", fs, 0);     chk("rst_tick", tick, 0);

    // Test 1/2/3/6: run 9 frames with ticks enabled
    rst = 1'b0;
    step(1);
    chk("t1_col1", col, 1);   chk("t1_fs_release", fs, 0);
    step(11);
    chk("t1_col12", col, 12); chk("t1_hs_off", hs, 0); chk("t1_hp_pre", hp, 1);
    step(2);
    chk("t1_col14", col, 14); chk("t1_hp_on", hp, 0);
    step(3);
    chk("t1_col17", col, 17); chk("t1_hp_end", hp, 1);
    step(3);
    chk("t1_wrap_col", col, 0); chk("t1_wrap_row", row, 1);
    step(20 * 6);              // cycle 140: row 7, first VSync pulse row
    chk("t2_row7", row, 7);   chk("t2_vp", vp, 0);    chk("t2_vs", vs, 0);
    step(40);                  // cycle 180: row 9
    chk("t2_row9", row, 9);   chk("t2_vp_end", vp, 1);
    step(FRAME * 9 - 180 + 5);
    chk("t2_nfs", fs_idx, 9);
    chk("t2_fs1_cyc", fs_cyc.size() > 0 ? fs_cyc[0] : -1, 200);
    chk("t2_fs2_cyc", fs_cyc.size() > 1 ? fs_cyc[1] : -1, 400);
    chk("t3_nticks", tick_at.size(), 3);
    chk("t3_tick_a", tick_at.size() > 0 ? tick_at[0] : -1, 3);
    chk("t3_tick_b", tick_at.size() > 1 ? tick_at[1] : -1, 6);
    chk("t3_tick_c", tick_at.size() > 2 ? tick_at[2] : -1, 9);
    chk("t3_tick1_n", tick1_n, 9);

    // Test 4: disable counting across frame starts 2..4
    rst = 1'b1;
    step(1);
    clear_log();
    rst = 1'b0;
    step(300);
    en = 1'b0;
    step(600);                 // frame starts 2,3,4 pass at 400/600/800
    en = 1'b1;
    step(305);                 // frame starts 5 (1000) and 6 (1200)
    chk("t4_nfs", fs_idx, 6);
    chk("t4_nticks", tick_at.size(), 1);
    chk("t4_tick_at", tick_at.size() > 0 ? tick_at[0] : -1, 6);
    chk("t4_tick1_n", tick1_n, 3);

    // Test 5: reset mid-frame after two counted frames
    rst = 1'b1;
    step(1);
    clear_log();
    rst = 1'b0;
    step(465);
    chk("t5_col", col, 5);    chk("t5_row", row, 3);
    rst = 1'b1;
    step(1);
    chk("t5_rcol", col, 0);   chk("t5_rrow", row, 0);
    chk("t5_rhs", hs, 1);     chk("t5_rvs", vs, 1);
    chk("t5_rhp", hp, 1);     chk("t5_rvp", vp, 1);
    chk("t5_rfs", fs, 0);
    clear_log();
    rst = 1'b0;
    step(405);
    chk("t5_no_early_tick", tick_at.size(), 0);
    step(200);
    chk("t5_nfs", fs_idx, 3);
    chk("t5_nticks", tick_at.size(), 1);
    chk("t5_tick_at", tick_at.size() > 0 ? tick_at[0] : -1, 3);

    chk_en = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
